collision_scan: RTL

Per-frame bullet/enemy collision scanner for the space shooter. On each frame-update `start` it snapshots all bullet and enemy positions, then walks every bullet/enemy pair, one pair per clock. For each hit it emits a one-cycle `updateScore` pulse, which drives the score counter's increment input directly. It also reports which bullets and enemies were destroyed so the sprite/position logic can retire them.

---
 rtl/collision_scan.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/collision_scan.sv
// collision_scan
//   Per-frame bullet/enemy collision scanner. A start request taken in IDLE
//   snapshots every bullet and enemy slot. The scanner then tests one
//   bullet/enemy pair per clock in bullet-major order. Each hit produces a
//   one-cycle updateScore pulse and marks the bullet and the enemy as
//   destroyed. A bullet or an enemy can be destroyed at most once per scan.
//
// Ports
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   start        in   scan request, only honoured in IDLE
//   bullet_x/y   in   packed bullet coordinates, slot i at [i*W +: W]
//   bullet_valid in   live-bullet mask
//   enemy_x/y    in   packed enemy coordinates, slot j at [j*W +: W]
//   enemy_valid  in   live-enemy mask
//   busy         out  high while in SCAN or DONE
//   updateScore  out  one-cycle pulse per hit
//   done         out  one-cycle pulse at scan completion
//   bullet_kill  out  bullets destroyed by the last scan
//   enemy_kill   out  enemies destroyed by the last scan
//   hit_count    out  hits in the last scan, saturating at 255
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; results of the previous scan are held
// SCAN  | evaluating pair k = i*NE + j against the snapshot
// DONE  | one-cycle done pulse, then back to IDLE
module collision_scan #(
  parameter int NB    = 4,
  parameter int NE    = 4,
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int HIT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [NB*XW-1:0] bullet_x,
  input  logic [NB*YW-1:0] bullet_y,
  input  logic [NB-1:0]    bullet_valid,
  input  logic [NE*XW-1:0] enemy_x,
  input  logic [NE*YW-1:0] enemy_y,
  input  logic [NE-1:0]    enemy_valid,
  output logic             busy,
  output logic             updateScore,
  output logic             done,
  output logic [NB-1:0]    bullet_kill,
  output logic [NE-1:0]    enemy_kill,
  output logic [7:0]       hit_count
);

  localparam int NP  = NB * NE;
  localparam int KW  = (NP > 1) ? $clog2(NP) : 1;
  localparam int IW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int JW  = (NE > 1) ? $clog2(NE) : 1;
  localparam int XW1 = XW + 1;
  localparam int YW1 = YW + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SCAN = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [KW-1:0]  K_LAST  = KW'(NP - 1);
  localparam logic [JW-1:0]  J_LAST  = JW'(NE - 1);
  localparam logic [XW1-1:0] HIT_X   = XW1'(HIT_W);
  localparam logic [YW1-1:0] HIT_Y   = YW1'(HIT_W);

  logic [1:0]       state;
  logic [KW-1:0]    k;
  // i and j are tracked as separate counters so that no divider is needed
  // for k / NE and k mod NE.
  logic [IW-1:0]    bi;
  logic [JW-1:0]    ej;

  logic [NB*XW-1:0] snap_bx;
  logic [NB*YW-1:0] snap_by;
  logic [NB-1:0]    snap_bv;
  logic [NE*XW-1:0] snap_ex;
  logic [NE*YW-1:0] snap_ey;
  logic [NE-1:0]    snap_ev;

  logic [XW-1:0]    arr_bx [NB];
  logic [YW-1:0]    arr_by [NB];
  logic [XW-1:0]    arr_ex [NE];
  logic [YW-1:0]    arr_ey [NE];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_bunpack
      assign arr_bx[gi] = snap_bx[gi*XW +: XW];
      assign arr_by[gi] = snap_by[gi*YW +: YW];
    end
    for (gi = 0; gi < NE; gi++) begin : g_eunpack
      assign arr_ex[gi] = snap_ex[gi*XW +: XW];
      assign arr_ey[gi] = snap_ey[gi*YW +: YW];
    end
  endgenerate

  logic [XW-1:0]  cur_bx, cur_ex;
  logic [YW-1:0]  cur_by, cur_ey;
  logic [XW1-1:0] dx, adx;
  logic [YW1-1:0] dy, ady;
  logic           near;
  logic           hit;

  // Zero-extended subtraction gives the signed difference with no
  // wrap-around: x = 0 and x = 255 really are 255 apart.
  always_comb begin
    cur_bx = arr_bx[bi];
    cur_by = arr_by[bi];
    cur_ex = arr_ex[ej];
    cur_ey = arr_ey[ej];
    dx     = {1'b0, cur_bx} - {1'b0, cur_ex};
    dy     = {1'b0, cur_by} - {1'b0, cur_ey};
    adx    = dx[XW] ? (~dx + XW1'(1)) : dx;
    ady    = dy[YW] ? (~dy + YW1'(1)) : dy;
    near   = (adx < HIT_X) && (ady < HIT_Y);
    hit    = (state == SCAN) && snap_bv[bi] && snap_ev[ej] &&
             !bullet_kill[bi] && !enemy_kill[ej] && near;
  end

  assign busy = (state == SCAN) || (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      k           <= '0;
      bi          <= '0;
      ej          <= '0;
      updateScore <= 1'b0;
      done        <= 1'b0;
      bullet_kill <= '0;
      enemy_kill  <= '0;
      hit_count   <= '0;
      snap_bx     <= '0;
      snap_by     <= '0;
      snap_bv     <= '0;
      snap_ex     <= '0;
      snap_ey     <= '0;
      snap_ev     <= '0;
    end else begin
      case (state)
        IDLE: begin
          updateScore <= 1'b0;
          done        <= 1'b0;
          if (start) begin
            snap_bx     <= bullet_x;
            snap_by     <= bullet_y;
            snap_bv     <= bullet_valid;
            snap_ex     <= enemy_x;
            snap_ey     <= enemy_y;
            snap_ev     <= enemy_valid;
            bullet_kill <= '0;
            enemy_kill  <= '0;
            hit_count   <= '0;
            k           <= '0;
            bi          <= '0;
            ej          <= '0;
            state       <= SCAN;
          end
        end

        SCAN: begin
          updateScore <= hit;
          if (hit) begin
            bullet_kill[bi] <= 1'b1;
            enemy_kill[ej]  <= 1'b1;
            if (hit_count != 8'hFF) begin
              hit_count <= hit_count + 8'd1;
            end
          end
          if (k == K_LAST) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            k <= k + KW'(1);
            if (ej == J_LAST) begin
              ej <= '0;
              bi <= bi + IW'(1);
            end else begin
              ej <= ej + JW'(1);
            end
          end
        end

        DONE: begin
          updateScore <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end

        default: begin
          updateScore <= 1'b0;
          done        <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule
